// File: rtl/afifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter for the async FIFO write port (wclk domain).
// Define AFIFO_ARB_PRIO_EN to make requester 0 high-priority in arbitration.
module afifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          wclk,
    input  logic                          wrst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    input  logic                          wfull,
    output logic                          winc,
    output logic [DATA_WIDTH-1:0]         wdata
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]        own_q, own_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]        beat_cnt_q, beat_cnt_d;
    logic                 prio_q, prio_d;
    logic [IW-1:0]        pick, cand;
    logic                 pick_ok, release_now;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            own_q      <= '0;
            rr_ptr_q   <= IW'(NUM_REQ - 1);
            beat_cnt_q <= '0;
            prio_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            own_q      <= own_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            prio_q     <= prio_d;
        end
    end

    // Circular search starting just after rr_ptr
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        cand    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IW'((int'(rr_ptr_q) + i) % NUM_REQ);
`ifdef AFIFO_ARB_PRIO_EN
            if (!pick_ok && req[cand] && cand != '0) begin
`else
            if (!pick_ok && req[cand]) begin
`endif
                pick    = cand;
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        own_d       = own_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        prio_d      = prio_q;
        winc        = 1'b0;
        wdata       = '0;
        ack         = '0;
        busy        = 1'b0;
        release_now = 1'b0;
        unique case (state_q)
            IDLE: begin
`ifdef AFIFO_ARB_PRIO_EN
                // After a priority grant, a waiting 1..N-1 requester goes first
                if (req[0] && !(prio_q && pick_ok)) begin
                    state_d    = LOCKED;
                    grant_d    = NUM_REQ'(1);
                    own_d      = '0;
                    beat_cnt_d = '0;
                    prio_d     = 1'b1;
                end else if (pick_ok) begin
                    state_d    = LOCKED;
                    grant_d    = NUM_REQ'(1) << pick;
                    own_d      = pick;
                    beat_cnt_d = '0;
                    prio_d     = 1'b0;
                end
`else
                if (pick_ok) begin
                    state_d    = LOCKED;
                    grant_d    = NUM_REQ'(1) << pick;
                    own_d      = pick;
                    beat_cnt_d = '0;
                end
`endif
            end
            LOCKED: begin
                busy = 1'b1;
                winc = req[own_q] & ~wfull;
                if (winc) begin
                    wdata      = req_data[int'(own_q)*DATA_WIDTH +: DATA_WIDTH];
                    ack        = grant_q;
                    beat_cnt_d = beat_cnt_q + CW'(1);
                end
                release_now = ~req[own_q] | (winc & (req_last[own_q] |
                              (beat_cnt_q == CW'(MAX_BURST - 1))));
                if (release_now) begin
                    state_d = IDLE;
                    grant_d = '0;
`ifdef AFIFO_ARB_PRIO_EN
                    if (own_q != '0) rr_ptr_d = own_q;
`else
                    rr_ptr_d = own_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant = grant_q;

endmodule
